// File: rtl/cnn_pkg.sv
// Shared constants and state/request encodings for the CNN memory-side blocks.
package cnn_pkg;

  localparam int DATA_SIZE  = 16;
  localparam int BLOCK_SIZE = 25;
  localparam int N          = 32;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    BLK_RD,
    IMG_RD,
    DONE
  } dma_state_t;

  typedef enum logic [1:0] {
    REQ_NONE,
    REQ_WRITE,
    REQ_BLK,
    REQ_IMG
  } req_kind_t;

endpackage

// File: rtl/dma_read_engine.sv
// Sequential read engine: issues base+i for i=0..length-1, one per cycle, and
// reports the capture slot one cycle later to match the RAM read latency.
module dma_read_engine #(
  parameter  int ADDR_W    = 16,
  parameter  int MAX_COUNT = 1024,
  localparam int CW        = $clog2(MAX_COUNT + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [CW-1:0]     length,
  output logic [ADDR_W-1:0] addr,
  output logic              issuing,
  output logic              cap_valid,
  output logic [CW-1:0]     cap_idx,
  output logic              finish
);

  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     len;
  logic [CW-1:0]     cnt;
  logic              active;

  // Address wraps naturally at the address width.
  assign issuing = active && (cnt < len);
  assign finish  = active && !issuing;
  assign addr    = base + ADDR_W'(cnt);

  // Latch the request on start, step the issue counter, and delay it for capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      base      <= '0;
      len       <= '0;
      cnt       <= '0;
      active    <= 1'b0;
      cap_valid <= 1'b0;
      cap_idx   <= '0;
    end else begin
      cap_valid <= issuing;
      cap_idx   <= cnt;
      if (start) begin
        base   <= start_addr;
        len    <= length;
        cnt    <= '0;
        active <= 1'b1;
      end else if (issuing) begin
        cnt <= cnt + CW'(1);
      end else if (finish) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/dma_responder.sv
// Memory-side responder: single-word writes, 25-word block reads and
// variable-length image reads against one single-port synchronous RAM.
module dma_responder
  import cnn_pkg::*;
#(
  parameter int DATA_SIZE  = cnn_pkg::DATA_SIZE,
  parameter int BLOCK_SIZE = cnn_pkg::BLOCK_SIZE,
  parameter int N          = cnn_pkg::N
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   dmaEnable,
  input  logic                                   loadEnable,
  input  logic                                   writeEnable,
  input  logic [DATA_SIZE-1:0]                   dmaAddress,
  input  logic signed [DATA_SIZE-1:0]            dmaInput,
  input  logic                                   loadImageEnable,
  input  logic [DATA_SIZE-1:0]                   loadImgAddress,
  input  logic [DATA_SIZE-1:0]                   imgSize,
  output logic signed [DATA_SIZE*BLOCK_SIZE-1:0] memFetchResult,
  output logic signed [DATA_SIZE*N*N-1:0]        fetchedImage,
  output logic                                   dmaDone,
  output logic                                   loadImageDone,
  output logic                                   busy,
  output logic [DATA_SIZE-1:0]                   memAddr,
  output logic                                   memWrEn,
  output logic [DATA_SIZE-1:0]                   memWrData,
  input  logic [DATA_SIZE-1:0]                   memRdData
);

  localparam int IMG_WORDS = N * N;
  localparam int CW        = $clog2(IMG_WORDS + 1);
  localparam int BIW       = $clog2(BLOCK_SIZE);
  localparam int IIW       = $clog2(IMG_WORDS);

  dma_state_t state, next_state;
  req_kind_t  req, kind;

  logic [DATA_SIZE-1:0] wr_addr;
  logic [DATA_SIZE-1:0] wr_data;
  logic [DATA_SIZE-1:0] last_addr;
  logic signed [DATA_SIZE-1:0] blk_buf [BLOCK_SIZE];
  logic signed [DATA_SIZE-1:0] img_buf [IMG_WORDS];

  logic [31:0]          img_prod;
  logic [CW-1:0]        img_len;
  logic [CW-1:0]        start_len;
  logic [DATA_SIZE-1:0] start_addr;
  logic                 eng_start;
  logic [DATA_SIZE-1:0] eng_addr;
  logic                 eng_issuing;
  logic                 eng_cap_valid;
  logic [CW-1:0]        eng_cap_idx;
  logic                 eng_finish;

  // Image word count: full 32-bit square, saturated to the buffer depth.
  assign img_prod  = 32'(imgSize) * 32'(imgSize);
  assign img_len   = (img_prod > 32'(IMG_WORDS)) ? CW'(IMG_WORDS) : CW'(img_prod);
  assign memWrData = wr_data;

  dma_read_engine #(
    .ADDR_W    (DATA_SIZE),
    .MAX_COUNT (IMG_WORDS)
  ) u_engine (
    .clk        (clk),
    .reset      (reset),
    .start      (eng_start),
    .start_addr (start_addr),
    .length     (start_len),
    .addr       (eng_addr),
    .issuing    (eng_issuing),
    .cap_valid  (eng_cap_valid),
    .cap_idx    (eng_cap_idx),
    .finish     (eng_finish)
  );

  // Request priority: write, then block read, then image read.
  always_comb begin
    req = REQ_NONE;
    if (dmaEnable && writeEnable)     req = REQ_WRITE;
    else if (dmaEnable && loadEnable) req = REQ_BLK;
    else if (loadImageEnable)         req = REQ_IMG;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode and per-state outputs; memAddr falls back to its last value.
  always_comb begin
    next_state    = state;
    eng_start     = 1'b0;
    start_len     = img_len;
    start_addr    = loadImgAddress;
    memWrEn       = 1'b0;
    busy          = 1'b1;
    dmaDone       = 1'b0;
    loadImageDone = 1'b0;
    memAddr       = eng_issuing ? eng_addr : last_addr;
    case (state)
      IDLE: begin
        busy = 1'b0;
        case (req)
          REQ_WRITE: next_state = WRITE;
          REQ_BLK: begin
            next_state = BLK_RD;
            eng_start  = 1'b1;
            start_len  = CW'(BLOCK_SIZE);
            start_addr = dmaAddress;
          end
          REQ_IMG: begin
            next_state = IMG_RD;
            eng_start  = 1'b1;
          end
          default: ;
        endcase
      end
      WRITE: begin
        memWrEn    = 1'b1;
        memAddr    = wr_addr;
        next_state = DONE;
      end
      BLK_RD, IMG_RD: if (eng_finish) next_state = DONE;
      DONE: begin
        dmaDone       = (kind != REQ_IMG);
        loadImageDone = (kind == REQ_IMG);
        next_state    = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch request kind and write fields on acceptance; remember the RAM address.
  always_ff @(posedge clk) begin
    if (reset) begin
      kind      <= REQ_NONE;
      wr_addr   <= '0;
      wr_data   <= '0;
      last_addr <= '0;
    end else begin
      last_addr <= memAddr;
      if (state == IDLE && req != REQ_NONE) kind <= req;
      if (state == IDLE && req == REQ_WRITE) begin
        wr_addr <= dmaAddress;
        wr_data <= dmaInput;
      end
    end
  end

  // Block-read capture buffer, written only during block reads.
  always_ff @(posedge clk) begin
    if (reset) blk_buf <= '{default: '0};
    else if (eng_cap_valid && state == BLK_RD) blk_buf[BIW'(eng_cap_idx)] <= memRdData;
  end

  // Image capture buffer, written only during image reads.
  always_ff @(posedge clk) begin
    if (reset) img_buf <= '{default: '0};
    else if (eng_cap_valid && state == IMG_RD) img_buf[IIW'(eng_cap_idx)] <= memRdData;
  end

  for (genvar g = 0; g < BLOCK_SIZE; g++) begin : g_blk
    assign memFetchResult[g*DATA_SIZE +: DATA_SIZE] = blk_buf[g];
  end

  for (genvar g = 0; g < IMG_WORDS; g++) begin : g_img
    assign fetchedImage[g*DATA_SIZE +: DATA_SIZE] = img_buf[g];
  end

endmodule

// File: tb/tb_dma_responder.sv
// Self-checking bench for dma_responder: directed steps plus randomized requests
// checked against a word-level memory/buffer reference model.
module tb_dma_responder;

  localparam int DW = 16;
  localparam int BS = 25;
  localparam int NN = 32;
  localparam int IW = NN * NN;

  logic clk = 1'b0;
  logic reset, init;
  logic dmaEnable, loadEnable, writeEnable, loadImageEnable;
  logic [DW-1:0] dmaAddress, dmaInput, loadImgAddress, imgSize;
  logic [DW*BS-1:0] memFetchResult;
  logic [DW*IW-1:0] fetchedImage;
  logic dmaDone, loadImageDone, busy, memWrEn;
  logic [DW-1:0] memAddr, memWrData, memRdData;

  always #5 clk = ~clk;

  dma_responder #(.DATA_SIZE(DW), .BLOCK_SIZE(BS), .N(NN)) dut (
    .clk             (clk),
    .reset           (reset),
    .dmaEnable       (dmaEnable),
    .loadEnable      (loadEnable),
    .writeEnable     (writeEnable),
    .dmaAddress      (dmaAddress),
    .dmaInput        (dmaInput),
    .loadImageEnable (loadImageEnable),
    .loadImgAddress  (loadImgAddress),
    .imgSize         (imgSize),
    .memFetchResult  (memFetchResult),
    .fetchedImage    (fetchedImage),
    .dmaDone         (dmaDone),
    .loadImageDone   (loadImageDone),
    .busy            (busy),
    .memAddr         (memAddr),
    .memWrEn         (memWrEn),
    .memWrData       (memWrData),
    .memRdData       (memRdData)
  );

  // Synchronous single-port RAM, contents RAM[k]=k after init.
  logic [DW-1:0] ram [65536];
  always @(posedge clk) begin
    if (init) begin
      for (int k = 0; k < 65536; k++) ram[k] <= 16'(k);
    end else if (memWrEn) begin
      ram[memAddr] <= memWrData;
    end
    memRdData <= ram[memAddr];
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [65536];
  logic [DW-1:0] ref_blk [BS];
  logic [DW-1:0] ref_img [IW];

  int n_checks = 0;
  int n_fail   = 0;
  bit last_ok;

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    last_ok = 1'b1;
    assert (obs === exp) else begin
      n_fail++;
      last_ok = 1'b0;
      $error("FAIL %s[%0d]: observed %0h expected %0h", tag, idx, obs, exp);
    end
  endtask

  task automatic check_bufs(input string tag);
    for (int i = 0; i < BS; i++) begin
      check({tag, "_blk"}, i, 32'(memFetchResult[i*DW +: DW]), 32'(ref_blk[i]));
      if (!last_ok) break;
    end
    for (int i = 0; i < IW; i++) begin
      check({tag, "_img"}, i, 32'(fetchedImage[i*DW +: DW]), 32'(ref_img[i]));
      if (!last_ok) break;
    end
  endtask

  // One request: drive for one sample edge, then scramble inputs to prove latching.
  task automatic run_op(input string tag, input bit de, input bit le, input bit we, input bit lie,
                        input logic [DW-1:0] da, input logic [DW-1:0] din,
                        input logic [DW-1:0] la, input logic [DW-1:0] sz);
    int kind, exp_lat, lat, limit, wr_seen, wr_cyc;
    longint cnt;
    logic [DW-1:0] wa, wd, addr_before, a;
    bit moved;
    if (de && we)      kind = 1;
    else if (de && le) kind = 2;
    else if (lie)      kind = 3;
    else               kind = 0;
    cnt = longint'(sz) * longint'(sz);
    if (cnt > IW) cnt = IW;
    case (kind)
      1:       exp_lat = 2;
      2:       exp_lat = BS + 2;
      3:       exp_lat = int'(cnt) + 2;
      default: exp_lat = 0;
    endcase
    limit = (kind == 0) ? 4 : exp_lat + 6;
    lat = 0; wr_seen = 0; wr_cyc = 0; wa = '0; wd = '0; moved = 1'b0;

    @(negedge clk);
    dmaEnable = de; loadEnable = le; writeEnable = we; loadImageEnable = lie;
    dmaAddress = da; dmaInput = din; loadImgAddress = la; imgSize = sz;
    addr_before = memAddr;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        dmaEnable = 1'b0; loadImageEnable = 1'b0;
        loadEnable = 1'($urandom); writeEnable = 1'($urandom);
        dmaAddress = 16'($urandom); dmaInput = 16'($urandom);
        loadImgAddress = 16'($urandom); imgSize = 16'($urandom);
      end
      if (memWrEn) begin
        wr_seen++; wr_cyc = c; wa = memAddr; wd = memWrData;
      end
      if (memAddr !== addr_before) moved = 1'b1;
      if (dmaDone || loadImageDone) begin
        lat = c;
        break;
      end
    end
    check({tag, "_latency"}, kind, 32'(lat), 32'(exp_lat));
    check({tag, "_dmaDone"}, kind, 32'(dmaDone), 32'(kind == 1 || kind == 2));
    check({tag, "_loadImageDone"}, kind, 32'(loadImageDone), 32'(kind == 3));
    check({tag, "_wr_count"}, kind, 32'(wr_seen), 32'(kind == 1));
    if (kind == 1) begin
      check({tag, "_wr_cycle"}, 0, 32'(wr_cyc), 32'd1);
      check({tag, "_wr_addr"}, 0, 32'(wa), 32'(da));
      check({tag, "_wr_data"}, 0, 32'(wd), 32'(din));
    end
    if (kind == 0 || (kind == 3 && cnt == 0))
      check({tag, "_addr_moved"}, 0, 32'(moved), 32'd0);
    @(posedge clk); #1;
    check({tag, "_done_after"}, 0, 32'({dmaDone, loadImageDone}), 32'd0);
    check({tag, "_busy_after"}, 0, 32'(busy), 32'd0);

    case (kind)
      1: ref_mem[da] = din;
      2: for (int i = 0; i < BS; i++) begin a = da + 16'(i); ref_blk[i] = ref_mem[a]; end
      3: for (int i = 0; i < int'(cnt); i++) begin a = la + 16'(i); ref_img[i] = ref_mem[a]; end
      default: ;
    endcase
    check_bufs(tag);
  endtask

  function automatic logic [DW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 16'hFFF0 + 16'($urandom_range(0, 15));
    return 16'h0500 + 16'($urandom_range(0, 40));
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, first, second, busy28, busy29;
    reset = 1'b1; init = 1'b1;
    dmaEnable = 1'b0; loadEnable = 1'b0; writeEnable = 1'b0; loadImageEnable = 1'b0;
    dmaAddress = '0; dmaInput = '0; loadImgAddress = '0; imgSize = '0;
    for (int k = 0; k < 65536; k++) ref_mem[k] = 16'(k);
    for (int i = 0; i < BS; i++) ref_blk[i] = '0;
    for (int i = 0; i < IW; i++) ref_img[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0; init = 1'b0;

    // Reset state
    check("rst_busy", 0, 32'(busy), 32'd0);
    check("rst_done", 0, 32'({dmaDone, loadImageDone}), 32'd0);
    check("rst_wren", 0, 32'(memWrEn), 32'd0);
    check("rst_addr", 0, 32'(memAddr), 32'd0);
    check("rst_wdata", 0, 32'(memWrData), 32'd0);
    check_bufs("rst");

    // Block read, write then read-back, image reads
    run_op("blk10", 1, 1, 0, 0, 16'h0010, 16'h0000, 16'h0000, 16'd0);
    run_op("wr200", 1, 0, 1, 0, 16'h0200, 16'hFFFB, 16'h0000, 16'd0);
    run_op("blk200", 1, 1, 0, 0, 16'h0200, 16'h0000, 16'h0000, 16'd0);
    run_op("img3", 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0400, 16'd3);
    run_op("img40", 0, 0, 0, 1, 16'h0000, 16'h0000, 16'hFE00, 16'd40);
    run_op("img3b", 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0800, 16'd3);
    run_op("img0", 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0900, 16'd0);

    // Priority, wrap, ignored strobe
    run_op("prio_all", 1, 1, 1, 1, 16'h0300, 16'h1234, 16'h0700, 16'd2);
    run_op("prio_blk", 1, 1, 0, 1, 16'h0300, 16'h0000, 16'h0700, 16'd2);
    run_op("wrap", 1, 1, 0, 0, 16'hFFF0, 16'h0000, 16'h0000, 16'd0);
    run_op("ignored", 1, 0, 0, 0, 16'h0100, 16'h5555, 16'h0000, 16'd0);

    // Reset at cycle 10 of a block read
    @(negedge clk);
    dmaEnable = 1'b1; loadEnable = 1'b1; dmaAddress = 16'h0300;
    seen = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin dmaEnable = 1'b0; loadEnable = 1'b0; end
      if (dmaDone) seen++;
      if (c == 10) reset = 1'b1;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < BS; i++) ref_blk[i] = '0;
    for (int i = 0; i < IW; i++) ref_img[i] = '0;
    check("midrst_busy", 0, 32'(busy), 32'd0);
    check("midrst_done", 0, 32'({dmaDone, loadImageDone}), 32'd0);
    check("midrst_addr", 0, 32'(memAddr), 32'd0);
    check("midrst_wdata", 0, 32'(memWrData), 32'd0);
    check_bufs("midrst");
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (dmaDone || loadImageDone || busy || memWrEn) seen++;
    end
    check("midrst_quiet", 0, 32'(seen), 32'd0);
    run_op("after_rst", 1, 1, 0, 0, 16'h0300, 16'h0000, 16'h0000, 16'd0);

    // Strobe held past done: a second block read must follow
    @(negedge clk);
    dmaEnable = 1'b1; loadEnable = 1'b1; writeEnable = 1'b0; loadImageEnable = 1'b0;
    dmaAddress = 16'h0040;
    first = 0; second = 0; busy28 = -1; busy29 = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (c == BS + 3) busy28 = int'(busy);
      if (c == BS + 4) busy29 = int'(busy);
      if (dmaDone) begin
        if (first == 0) first = c;
        else if (second == 0) second = c;
      end
      if (first != 0 && c == first + 3) begin dmaEnable = 1'b0; loadEnable = 1'b0; end
      if (second != 0) break;
    end
    check("held_first", 0, 32'(first), 32'(BS + 2));
    check("held_second", 0, 32'(second), 32'(2 * (BS + 2) + 1));
    check("held_busy_idle", 0, 32'(busy28), 32'd0);
    check("held_busy_rd", 0, 32'(busy29), 32'd1);
    @(posedge clk); #1;
    check("held_busy_end", 0, 32'(busy), 32'd0);
    for (int i = 0; i < BS; i++) ref_blk[i] = ref_mem[16'h0040 + 16'(i)];
    check_bufs("held");
    run_op("img_after_blk", 0, 0, 0, 1, 16'h0000, 16'h0000, 16'h0600, 16'd4);

    // Randomized requests
    for (int t = 0; t < 24; t++) begin
      run_op("rand",
             $urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0, 1'($urandom),
             rnd_addr(), 16'($urandom), rnd_addr(), 16'($urandom_range(0, 9)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_responder.md
Name: dma_responder

Overview:
- Memory-side responder for the CNN controller's DMA and image-load requests.
- Serves three request types against one single-port synchronous RAM:
  - 25-word block reads (layer headers, filters, previous partial sums).
  - Variable-length image reads (imgSize×imgSize words).
  - Single-word writes (conv/pool results).
- Signals completion with dmaDone or loadImageDone pulses and sits between cnn_controller and the data RAM.

Parameters:
- DATA_SIZE, 16, word and address width.
- BLOCK_SIZE, 25, words per block read.
- N, 32, maximum image side; image buffer depth is N*N.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- dmaEnable  in  1  DMA request strobe (level).
- loadEnable  in  1  with dmaEnable: block read.
- writeEnable  in  1  with dmaEnable: single-word write.
- dmaAddress  in  DATA_SIZE  block-read or write address.
- dmaInput  in  DATA_SIZE  signed write data.
- loadImageEnable  in  1  image read request (level).
- loadImgAddress  in  DATA_SIZE  image start address.
- imgSize  in  DATA_SIZE  image side length.
- memFetchResult  out  DATA_SIZE×BLOCK_SIZE  signed block-read buffer.
- fetchedImage  out  DATA_SIZE×N*N  signed image buffer.
- dmaDone  out  1  one-cycle pulse: block read or write complete.
- loadImageDone  out  1  one-cycle pulse: image read complete.
- busy  out  1  high in any non-IDLE state.
- memAddr  out  DATA_SIZE  RAM address.
- memWrEn  out  1  RAM write enable.
- memWrData  out  DATA_SIZE  RAM write data.
- memRdData  in  DATA_SIZE  RAM read data, valid 1 cycle after memAddr.

Behaviour:
- Reset:
  - State goes to IDLE.
  - All outputs are 0, including every entry of memFetchResult and fetchedImage.
  - Internal counters and latched request fields are cleared.
  - Reset mid-operation aborts immediately; no further memWrEn; no done pulse.
- States: IDLE, WRITE, BLK_RD, IMG_RD, DONE.
- IDLE request sampling, priority when several requests are active together:
  1. dmaEnable&&writeEnable → WRITE.
  2. dmaEnable&&loadEnable → BLK_RD.
  3. loadImageEnable → IMG_RD.
  - On entry, address, data and length are latched. Later changes to the inputs are ignored until the operation ends.
  - dmaEnable with neither loadEnable nor writeEnable is ignored.
- WRITE:
  - memAddr=addr, memWrData=data, memWrEn=1 for exactly one cycle, then DONE.
  - Latency: request sampled at cycle 0, memWrEn high in cycle 1, dmaDone high in cycle 2.
- BLK_RD:
  - Issues addr+i for i=0..BLOCK_SIZE-1, one per cycle.
  - memRdData captured into memFetchResult[i] one cycle after its address.
  - After the last capture, go to DONE; dmaDone high the next cycle.
  - Total latency from sample to dmaDone is BLOCK_SIZE+2 cycles (27).
- IMG_RD:
  - count = imgSize*imgSize, computed as a 32-bit product and saturated to N*N.
  - Words are captured into fetchedImage[0..count-1]; entries ≥count keep their previous values.
  - count==0 goes straight to DONE with no memory access.
  - Latency is count+2 cycles.
- DONE:
  - Pulses dmaDone (WRITE, BLK_RD) or loadImageDone (IMG_RD) for 1 cycle, then returns to IDLE.
  - A request still asserted in IDLE after DONE is a new request. The requester must drop its strobe on the done edge.
- Addresses increment modulo 2^DATA_SIZE; 0xFFFF+1 wraps to 0x0000.
- memWrEn is 1 only in WRITE; memAddr holds its last value when idle.
- Buffers are only written during their own read type. memFetchResult is stable through image reads, and vice versa.
- busy=1 in WRITE, BLK_RD, IMG_RD and DONE.

Decomposition:
- Shared package cnn_pkg holds:
  - DATA_SIZE, BLOCK_SIZE and N constants.
  - The state enum dma_state_t {IDLE, WRITE, BLK_RD, IMG_RD, DONE}.
  - The request-kind enum.
- One natural sub-module, dma_read_engine:
  - Address/counter generator plus a one-cycle-delayed capture index.
  - Parameterised by the maximum count.
  - Instanced once and shared by BLK_RD and IMG_RD via a length input.

Test Plan:
1. Reset with RAM[k]=k: dmaEnable=1, loadEnable=1, dmaAddress=0x0010 → memFetchResult[i]=0x10+i for i=0..24; dmaDone single pulse 27 cycles after the sample; busy low the next cycle.
2. Write: dmaEnable=1, writeEnable=1, dmaAddress=0x0200, dmaInput=0xFFFB (-5) → memWrEn high for exactly 1 cycle with memAddr=0x0200, memWrData=0xFFFB; dmaDone 2 cycles after the sample; a subsequent block read at 0x0200 returns -5 in entry 0.
3. Image read: loadImageEnable=1, loadImgAddress=0x0400, imgSize=3 → fetchedImage[0..8]=RAM[0x400..0x408], loadImageDone after 11 cycles; entries 9..1023 unchanged. imgSize=0 → loadImageDone 2 cycles after the sample, no memAddr change. imgSize=40 → 1024 words captured.
4. Priority and wrap: writeEnable, loadEnable and loadImageEnable all asserted with dmaEnable → write serviced first. Block read at 0xFFF0 → entries 0..15 from 0xFFF0..0xFFFF, entries 16..24 from 0x0000..0x0008.
5. Reset mid-op: assert reset at cycle 10 of a block read → no dmaDone, all outputs 0, state IDLE next cycle; a new request afterwards completes normally.
6. Strobe held: dmaEnable held high 3 cycles past dmaDone → second block read starts; memFetchResult is stable during a following image read.
